// File: rtl/oai22_pkg.sv
// Shared definitions for the registered 2-2 complex-gate pipeline.
// Function select encoding and the per-bit gate function.
package oai22_pkg;

    typedef enum logic [1:0] {
        MODE_OAI22 = 2'b00,
        MODE_AOI22 = 2'b01,
        MODE_OA22  = 2'b10,
        MODE_AO22  = 2'b11
    } mode_e;

    // Single-bit gate; callers apply it across any operand width bit by bit.
    function automatic logic cplx22_f(
        input logic  a,
        input logic  b,
        input logic  c,
        input logic  d,
        input mode_e mode
    );
        logic or_and;
        logic and_or;
        logic r;
        or_and = (a | b) & (c | d);
        and_or = (a & b) | (c & d);
        case (mode)
            MODE_OAI22: r = ~or_and;
            MODE_AOI22: r = ~and_or;
            MODE_OA22:  r = or_and;
            default:    r = and_or;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/oai22_pipe_stage.sv
// One pipeline slot: valid bit plus W-bit result, loaded whenever ld is high.
// Data loads regardless of incoming valid; holds both when ld is low.
module oai22_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         vld_in,
    input  logic [W-1:0] dat_in,
    output logic         vld,
    output logic [W-1:0] dat
);

    logic         vld_d, vld_q;
    logic [W-1:0] dat_d, dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ld) begin
            vld_d = vld_in;
            dat_d = dat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule

// File: rtl/oai22_pipe.sv
// Selectable OAI22/AOI22/OA22/AO22 applied bitwise, carried through a STAGES-deep
// valid/ready pipeline with collapsing bubbles and a wrapping delivered-result counter.
module oai22_pipe
    import oai22_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    input  logic [W-1:0]     D,
    input  logic [1:0]       MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [W-1:0]     Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] OUT_CNT
);

    logic [W-1:0]             f_dat;
    logic [STAGES-1:0]        v;
    logic [STAGES-1:0]        rdy;
    logic [STAGES-1:0][W-1:0] dat;
    logic [CNT_W-1:0]         cnt_d, cnt_q;

    always_comb begin
        f_dat = '0;
        for (int b = 0; b < W; b++) begin
            f_dat[b] = cplx22_f(A[b], B[b], C[b], D[b], mode_e'(MODE));
        end
    end

    // Flattened ready chain: stage i can load unless it and every stage after
    // it are occupied while the consumer stalls.
    always_comb begin
        logic tail_full;
        rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                tail_full = tail_full & v[j];
            end
            rdy[i] = ~tail_full | OUT_READY;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                oai22_pipe_stage #(.W(W)) u_stage (
                    .clk    (CLK),
                    .rst    (RST),
                    .ld     (rdy[gi]),
                    .vld_in (IN_VALID),
                    .dat_in (f_dat),
                    .vld    (v[gi]),
                    .dat    (dat[gi])
                );
            end else begin : g_body
                oai22_pipe_stage #(.W(W)) u_stage (
                    .clk    (CLK),
                    .rst    (RST),
                    .ld     (rdy[gi]),
                    .vld_in (v[gi-1]),
                    .dat_in (dat[gi-1]),
                    .vld    (v[gi]),
                    .dat    (dat[gi])
                );
            end
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (OUT_VALID && OUT_READY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign IN_READY  = rdy[0];
    assign OUT_VALID = v[STAGES-1];
    assign Y         = dat[STAGES-1];
    assign OUT_CNT   = cnt_q;

endmodule

// File: tb/tb_oai22_pipe.sv
// Bench for oai22_pipe (W=4, STAGES=2, CNT_W=3): directed scenarios plus random
// traffic, all checked against an in-order queue model of in-flight entries.
module tb_oai22_pipe;

    localparam int W      = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 3;

    logic             CLK;
    logic             RST;
    logic [W-1:0]     A, B, C, D;
    logic [1:0]       MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     Y;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [CNT_W-1:0] OUT_CNT;

    oai22_pipe #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .MODE      (MODE),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .Y         (Y),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CNT   (OUT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] y;
        int           t;
    } ent_t;

    ent_t q[$];
    int   cyc;
    int   mcnt;
    int   total;
    int   bad;
    logic last_ir;
    int   acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, b, c, d, input logic [1:0] m);
        case (m)
            2'd0:    return ~((a | b) & (c | d));
            2'd1:    return ~((a & b) | (c & d));
            2'd2:    return (a | b) & (c | d);
            default: return (a & b) | (c & d);
        endcase
    endfunction

    // The oldest entry is never blocked by anything ahead of it, so it reaches
    // the output exactly STAGES-1 edges after the edge that accepted it.
    task automatic cycle(input logic iv, input logic [W-1:0] a, b, c, d,
                         input logic [1:0] m, input logic ordy);
        logic exp_ov, exp_ir;
        ent_t e;
        IN_VALID  = iv;
        A = a; B = b; C = c; D = d;
        MODE      = m;
        OUT_READY = ordy;
        @(negedge CLK);
        exp_ov = (q.size() > 0) && (cyc - q[0].t >= STAGES - 1);
        exp_ir = (q.size() < STAGES) || ordy;
        chk("in_ready", IN_READY, exp_ir);
        chk("out_valid", OUT_VALID, exp_ov);
        if (exp_ov) chk("y", Y, q[0].y);
        chk("out_cnt", OUT_CNT, mcnt);
        last_ir = IN_READY;
        @(posedge CLK);
        cyc++;
        if (exp_ov && ordy) begin
            void'(q.pop_front());
            mcnt = (mcnt + 1) % (1 << CNT_W);
        end
        if (iv && exp_ir) begin
            e.y = ref_f(a, b, c, d, m);
            e.t = cyc;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, ordy);
    endtask

    task automatic async_reset();
        #2 RST = 1'b1;
        #1;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_y", Y, 4'h0);
        chk("rst_out_cnt", OUT_CNT, 3'd0);
        chk("rst_in_ready", IN_READY, 1'b1);
        q.delete();
        mcnt = 0;
        #1 RST = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; mcnt = 0; acc = 0;
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; C = '0; D = '0; MODE = 2'd0;

        // Power-up reset asserted between clock edges.
        #3 RST = 1'b1;
        #1;
        chk("por_out_valid", OUT_VALID, 1'b0);
        chk("por_y", Y, 4'h0);
        chk("por_out_cnt", OUT_CNT, 3'd0);
        chk("por_in_ready", IN_READY, 1'b1);
        #8 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Truth check, all four modes back to back.
        for (int m = 0; m < 4; m++) cycle(1'b1, 4'b1100, 4'b1010, 4'b0110, 4'b0001, 2'(m), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure fill then drain.
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 4'(k), 4'hF, 4'(k + 3), 4'h5, 2'(k), 1'b0);
            if (last_ir) acc++;
        end
        chk("fill_accepted", acc, 2);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Bubble collapse: second entry accepted while the first is stalled.
        cycle(1'b1, 4'h9, 4'h3, 4'h6, 4'hC, 2'd2, 1'b0);
        idle(1'b0);
        cycle(1'b1, 4'h5, 4'hA, 4'h1, 4'h8, 2'd1, 1'b0);
        chk("bubble_accepted", last_ir, 1'b1);
        idle(1'b0);
        chk("full_in_ready", last_ir, 1'b0);
        // Simultaneous out and in on a full pipe.
        cycle(1'b1, 4'h7, 4'h7, 4'h0, 4'hE, 2'd3, 1'b1);
        chk("full_passthru_ready", last_ir, 1'b1);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Counter wrap: streaming traffic pushes OUT_CNT through 7 -> 0 -> 1.
        for (int k = 0; k < 12; k++)
            cycle(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Mid-stream reset with two entries in flight.
        cycle(1'b1, 4'h3, 4'h4, 4'h5, 4'h6, 2'd0, 1'b0);
        cycle(1'b1, 4'hA, 4'hB, 4'hC, 4'hD, 2'd1, 1'b0);
        async_reset();
        for (int k = 0; k < 5; k++) idle(1'b1);

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 2'($urandom), 1'($urandom_range(0, 9) < 6));
        for (int k = 0; k < 4; k++) idle(1'b1);
        chk("drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
